muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative unsigned multiply/divide unit in the execute stage, directly upstream of the register file. Takes the two register-file read operands and a destination index, computes over 32 cycles, then presents a result on a writeback port whose `wb_valid`/`wb_rd`/`wb_data` map onto the register file's write-enable/`rd`/`write_data`. Backpressure via `wb_ready` lets the port be shared with the ALU writeback path.

## Interface
- `XLEN`, 32: operand/result width. The iteration count equals `XLEN`.
- `clk`  input  1  single clock. All state changes on rising edge.
- `rst`  input  1  reset. One clock; reset is asynchronous and active-low.
- `start`  input  1  request; accepted only in IDLE.
- `op`  input  2  00 MUL (low word), 01 MULH (high word), 10 DIVU (quotient), 11 REMU (remainder).
- `rs_data`  input  XLEN  operand A: multiplicand or dividend.
- `rt_data`  input  XLEN  operand B: multiplier or divisor.
- `dest`  input  5  destination register index.
- `flush`  input  1  abort any operation.
- `busy`  output  1  high in RUN and DONE.
- `wb_valid`  output  1  result available (high in DONE).
- `wb_rd`  output  5  latched `dest`.
- `wb_data`  output  XLEN  result.
- `wb_ready`  input  1  consumer takes the result this cycle.

## Operation
- States:
  - IDLE: `start` = 1 → latch `op`, `dest`, operands. Clear counter. Go to RUN. Exception: DIVU/REMU with `rt_data` = 0 goes directly to DONE.
  - RUN: one iteration per edge. After the 32nd iteration go to DONE.
  - DONE: `wb_valid` = 1. Go to IDLE on an edge with `wb_ready` = 1.
- Multiply uses a shift-add algorithm:
  - 64-bit register {hi, lo}, initialised to {0, B}.
  - Each iteration: if lo[0] = 1, form a 33-bit sum hi + A; then shift {carry, hi, lo} right by 1.
  - MUL returns lo. MULH returns hi.
- Divide uses restoring division:
  - Remainder register is XLEN+1 bits, initialised to 0. Quotient register is initialised to A.
  - Each iteration: shift {rem, quo} left by 1; trial-subtract B; if non-negative, keep the difference and set quo[0] = 1.
  - DIVU returns quo. REMU returns rem[XLEN-1:0].
- Divide by zero: quotient = all ones (0xFFFFFFFF), remainder = A. No iterations are performed.
- `dest` = 0 is computed and presented normally. Dropping the write is the register file's job.
- `start` in RUN or DONE is ignored. There is no queueing.
- `flush` = 1 moves any state to IDLE on the next edge, discarding the result. `flush` has priority over `start` and `wb_ready`.
- `wb_rd` and `wb_data` are stable throughout DONE. Outside DONE their values are don't-care.

## Timing
- Reset (`rst` = 0, asynchronous):
  - State goes to IDLE.
  - `busy` = 0, `wb_valid` = 0, `wb_rd` = 0, `wb_data` = 0, counter = 0.
  - Reset during RUN or DONE abandons the operation. No writeback follows.
- Cycle numbering: edge 0 samples `start` = 1 in IDLE; `busy` = 1 from then.
  - Normal operation: edges 1..32 perform the iterations. `wb_valid` = 1 after edge 32, so latency is 32 cycles.
  - Divide by zero: `wb_valid` = 1 after edge 0, so latency is 1 cycle.
- Release of the result:
  - An edge with `wb_valid` = 1 and `wb_ready` = 1 returns to IDLE; `busy` and `wb_valid` = 0 after it.
  - Minimum spacing between accepts is 34 edges (a new `start` is accepted on the edge after the return to IDLE).
  - `wb_ready` held 0 holds DONE indefinitely.
- `busy` and `wb_valid` are registered outputs, with no combinational path from inputs. `wb_data` is a mux of registered state selected by the latched `op`.

## Test plan
- Reset and first multiply:
  - Hold `rst` = 0 → all outputs 0.
  - Release, then MUL 7 × 6, `dest` = 5, `wb_ready` = 1 → `wb_valid` for exactly one cycle, 32 cycles after accept, with `wb_rd` = 5 and `wb_data` = 42.
- MULH and MUL with 0xFFFFFFFF × 0xFFFFFFFF → MULH gives 0xFFFFFFFE; MUL gives 0x00000001.
- DIVU 100 / 7 → 14. REMU 100 / 7 → 2. REMU 5 / 9 → 5.
- Divide by zero:
  - DIVU 0x1234 / 0 → `wb_data` = 0xFFFFFFFF with `wb_valid` one cycle after accept.
  - REMU 0x1234 / 0 → 0x1234.
- Backpressure:
  - Hold `wb_ready` = 0 for 5 cycles in DONE → `wb_valid`, `wb_rd` and `wb_data` stay stable and `busy` = 1.
  - Pulse `start` during the stall → ignored; the result is unchanged.
  - Raise `wb_ready` → IDLE on the next edge.
- Abort:
  - `flush` at RUN iteration 10 → IDLE next edge, no `wb_valid`. A following MUL 3 × 3 → 9.
  - Repeat with `rst` asserted mid-RUN → outputs 0 immediately, no `wb_valid`.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with a backpressured writeback port.
// MUL/MULH use shift-add and DIVU/REMU use restoring division. Each takes XLEN
// iterations. Divide by zero skips the iterations and finishes in one cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic [4:0]      dest,
  input  logic            flush,
  output logic            busy,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            wb_ready
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIVU = 2'b10,
    OP_REMU = 2'b11
  } op_t;

  state_t          state_q, state_d;
  op_t             op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] opnd_q;   // multiplicand A for multiply, divisor B for divide
  logic [XLEN:0]   hi_q;     // product high word, or the XLEN+1 bit remainder
  logic [XLEN-1:0] lo_q;     // product low word / multiplier, or the quotient
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic            div_by_zero;
  logic            last_iter;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN:0]   hi_step;
  logic [XLEN-1:0] lo_step;

  assign accept      = start && (state_q == S_IDLE) && !flush;
  assign div_by_zero = op[1] && (rt_data == '0);
  assign last_iter   = (cnt_q == CW'(XLEN - 1));

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic. Flush overrides start and wb_ready.
  // NOTE: default assigned first so no path through the block leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start)     state_d = div_by_zero ? S_DONE : S_RUN;
        S_RUN:  if (last_iter) state_d = S_DONE;
        S_DONE: if (wb_ready)  state_d = S_IDLE;
        default:               state_d = S_IDLE;
      endcase
    end
  end

  // One iteration of the selected algorithm, computed from the current registers.
  always_comb begin
    mul_sum   = {1'b0, hi_q[XLEN-1:0]} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    hi_step   = div_shift;
    lo_step   = {lo_q[XLEN-2:0], 1'b0};
    if (op_q[1]) begin
      // A clear top bit means the trial subtraction did not go negative.
      if (!div_diff[XLEN]) begin
        hi_step = div_diff;
        lo_step = {lo_q[XLEN-2:0], 1'b1};
      end
    end else begin
      // Shift {carry, hi, lo} right by one. The carry becomes the new top of hi.
      hi_step = {1'b0, mul_sum[XLEN:1]};
      lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Operand latch, iteration registers and counter.
  // NOTE: the datapath is reset as well, because wb_rd and wb_data must read zero during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= OP_MUL;
      rd_q   <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      op_q  <= op_t'(op);
      rd_q  <= dest;
      cnt_q <= '0;
      if (op[1]) begin
        opnd_q <= rt_data;
        if (div_by_zero) begin
          hi_q <= {1'b0, rs_data};   // remainder = dividend
          lo_q <= '1;                // quotient = all ones
        end else begin
          hi_q <= '0;
          lo_q <= rs_data;
        end
      end else begin
        opnd_q <= rs_data;
        hi_q   <= '0;
        lo_q   <= rt_data;
      end
    end else if (state_q == S_RUN && !flush) begin
      hi_q  <= hi_step;
      lo_q  <= lo_step;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign wb_valid = (state_q == S_DONE);
  assign wb_rd    = rd_q;

  // Result select by the latched op.
  always_comb begin
    wb_data = lo_q;
    unique case (op_q)
      OP_MUL, OP_DIVU: wb_data = lo_q;
      OP_MULH, OP_REMU: wb_data = hi_q[XLEN-1:0];
      default:         wb_data = lo_q;
    endcase
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. A vector table and random ops feed a
// scoreboard. Hand-written sequences cover backpressure, flush and reset in mid-run.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  dest;
  logic        flush;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  wb_t  sb[$];
  vec_t vecs[9];

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dest     (dest),
    .flush    (flush),
    .busy     (busy),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_ready (wb_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    case (o)
      2'b00:   return prod[31:0];
      2'b01:   return prod[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op from IDLE with wb_ready = 1. Called and returns #1 after a rising edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
    int  edge_idx;
    wb_t got;
    op      = o;
    rs_data = a;
    rt_data = b;
    dest    = rd;
    start   = 1'b1;
    sb.push_back(wb_t'({rd, exp}));
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    edge_idx = 0;
    while (!wb_valid && edge_idx < 40) begin
      @(posedge clk); #1;
      edge_idx++;
    end
    check("latency", edge_idx, exp_lat);
    if (wb_valid) begin
      if (sb.size() == 0) begin
        check("scoreboard_nonempty", 0, 1);
      end else begin
        got = sb.pop_front();
        check("wb_rd", wb_rd, got.rd);
        check("wb_data", wb_data, got.data);
      end
    end else begin
      check("wb_valid_timeout", 0, 1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    @(posedge clk); #1;
    check("valid_one_cycle", wb_valid, 0);
    check("idle_after_release", busy, 0);
  endtask

  initial begin
    int          edge_idx;
    logic        seen_valid;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{2'b00, 32'd7,          32'd6,          5'd5,  32'd42,         32};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE,  32};
    vecs[2] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0001,  32};
    vecs[3] = '{2'b10, 32'd100,        32'd7,          5'd10, 32'd14,         32};
    vecs[4] = '{2'b11, 32'd100,        32'd7,          5'd11, 32'd2,          32};
    vecs[5] = '{2'b11, 32'd5,          32'd9,          5'd12, 32'd5,          32};
    vecs[6] = '{2'b10, 32'h1234,       32'd0,          5'd13, 32'hFFFF_FFFF,  0};
    vecs[7] = '{2'b11, 32'h1234,       32'd0,          5'd14, 32'h1234,       0};
    vecs[8] = '{2'b00, 32'd1000,       32'd1000,       5'd0,  32'd1000000,    32};

    rst      = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    rs_data  = '0;
    rt_data  = '0;
    dest     = '0;
    flush    = 1'b0;
    wb_ready = 1'b1;

    // Reset values
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);

    // Random ops against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom);
      run_op(ro, ra, rb, 5'(i + 16), model(ro, ra, rb), (ro[1] && rb == 0) ? 0 : 32);
    end

    // Backpressure: hold DONE and pulse start while stalled
    wb_ready = 1'b0;
    op = 2'b10; rs_data = 32'd100; rt_data = 32'd7; dest = 5'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edge_idx = 0;
    while (!wb_valid && edge_idx < 40) begin
      @(posedge clk); #1;
      edge_idx++;
    end
    check("bp_latency", edge_idx, 32);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", wb_valid, 1);
      check("bp_rd", wb_rd, 5'd3);
      check("bp_data", wb_data, 32'd14);
      check("bp_busy", busy, 1);
      if (k == 1) begin
        op = 2'b00; rs_data = 32'd3; rt_data = 32'd3; dest = 5'd9;
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("bp_after_start_rd", wb_rd, 5'd3);
    check("bp_after_start_data", wb_data, 32'd14);
    wb_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", wb_valid, 0);
    check("bp_release_busy", busy, 0);
    @(posedge clk); #1;
    check("bp_no_queued_start", busy, 0);

    // Flush at iteration 10
    op = 2'b00; rs_data = 32'hFFFF; rt_data = 32'hFFFF; dest = 5'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_valid", wb_valid, 0);
    seen_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      seen_valid |= wb_valid;
    end
    check("flush_no_writeback", seen_valid, 0);
    run_op(2'b00, 32'd3, 32'd3, 5'd4, 32'd9, 32);

    // Reset asserted mid-RUN
    op = 2'b00; rs_data = 32'd5; rt_data = 32'd5; dest = 5'd6;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", wb_valid, 0);
    check("midrst_rd", wb_rd, 0);
    check("midrst_data", wb_data, 0);
    @(negedge clk) rst = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      seen_valid |= wb_valid;
    end
    check("midrst_no_writeback", seen_valid, 0);
    run_op(2'b00, 32'd3, 32'd3, 5'd8, 32'd9, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
